nx_stream_arbiter_rr: RTL and testbench
=======================================

Name: nx_stream_arbiter_rr

Overview:
Parametrised next-generation inbound stream arbiter for the node. It merges PORTS valid/ready message streams into one registered output stream that feeds the message decoder, and tags each message with the index of the port it came from. Arbitration is either fair round-robin or fixed-priority, chosen at elaboration. The registered output stage cuts the combinational path from the mesh links to the decoder. Throughput is one message per cycle.

Parameters:
- STREAM_WIDTH, 32, message width in bits.
- PORTS, 4, number of inbound streams (1..16).
- DIR_WIDTH, (PORTS > 1) ? $clog2(PORTS) : 1, width of the source-index tag. Derived; do not override.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, where the lowest index wins.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset. Asynchronous assert, active-low.
- in_data_i, in, PORTS*STREAM_WIDTH, flattened inbound data. Port p occupies bits [p*STREAM_WIDTH +: STREAM_WIDTH].
- in_valid_i, in, PORTS, per-port valid.
- in_ready_o, out, PORTS, per-port ready. At most one bit is set at a time.
- arb_data_o, out, STREAM_WIDTH, arbitrated message.
- arb_dir_o, out, DIR_WIDTH, index of the source port.
- arb_valid_o, out, 1, output valid.
- arb_ready_i, in, 1, downstream ready.
- idle_o, out, 1, high when no message is held and no input is valid.
- grant_count_o, out, PORTS*16, per-port grant counters. Present only with NX_ARB_STATS_EN.
- stats_clear_i, in, 1, synchronous clear of the counters. Present only with NX_ARB_STATS_EN.

Behaviour:
- Reset (rst_i low):
  - arb_valid_o=0, arb_data_o=0, arb_dir_o=0.
  - Round-robin pointer last_q=PORTS-1, so port 0 has first priority.
  - Counters=0.
  - A held message is discarded when reset asserts mid-operation.
- Handshake:
  - A transfer on a port or on the output occurs when valid && ready are both high on a rising edge.
  - Senders hold data stable while valid is high and ready is low.
  - Valid never depends on ready.
- Load condition: can_load = !arb_valid_o || arb_ready_i.
- Grant (combinational):
  - When can_load is high and any in_valid_i bit is set, exactly one port g is granted and in_ready_o[g]=1.
  - All other ready bits are 0.
  - When can_load is low, in_ready_o is all zeros.
- Round-robin (RR_MODE=1):
  - Search from (last_q+1) mod PORTS upward, wrapping through index PORTS-1 back to 0.
  - g is the first valid port found.
  - On a grant, last_q<=g. With no grant, last_q holds.
- Fixed priority (RR_MODE=0): g is the lowest valid index. last_q is unused.
- Output register:
  - On a grant: arb_data_o<=in_data_i[g], arb_dir_o<=g, arb_valid_o<=1.
  - On an output transfer with no new grant: arb_valid_o<=0. arb_data_o and arb_dir_o keep their values.
  - Simultaneous output transfer and new grant: the register is replaced in the same cycle, with no bubble.
- Latency: one cycle from input transfer to arb_valid_o.
- Sustained throughput: one message per cycle while arb_ready_i stays high.
- Backpressure: with arb_valid_o=1 and arb_ready_i=0, all inputs stall and the output is stable.
- idle_o = !arb_valid_o && (in_valid_i == 0). Purely combinational.
- PORTS=1: the grant is always port 0, arb_dir_o is always 0, and the pointer is constant.
- A valid input is never granted twice for one transfer. An input dropping valid without a transfer is a protocol violation; behaviour is then undefined.

Optional Feature:
NX_ARB_STATS_EN
- Defined:
  - grant_count_o and stats_clear_i exist.
  - Each port has a 16-bit counter that increments on every input transfer from that port.
  - Counters saturate at 16'hFFFF and do not wrap.
  - stats_clear_i=1 zeroes all counters on the next edge. It overrides an increment in the same cycle.
- Undefined: these ports and all counter logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset value: PORTS=4, RR_MODE=1, hold rst_i low, then release. Expect arb_valid_o=0, in_ready_o=4'b0000, idle_o=1. Then drive only port 2 valid with data 32'hA5 and arb_ready_i=1. Expect in_ready_o=4'b0100, and next cycle arb_valid_o=1, arb_data_o=32'hA5, arb_dir_o=2.
- Round-robin fairness: all 4 ports continuously valid, arb_ready_i=1. Expect grants 0,1,2,3,0,1… one per cycle. Output dir sequence 0,1,2,3 with no idle cycles.
- Backpressure: output holding data from port 1, arb_ready_i=0 for 3 cycles. Expect in_ready_o=0, and arb_data_o and arb_dir_o stable. Then raise arb_ready_i with port 3 valid. Expect same-cycle handoff: the next output is from port 3, with no bubble.
- Fixed priority: RR_MODE=0 with ports 1 and 3 valid. Port 1 is granted repeatedly; port 3 is granted only after port 1 drops valid.
- Wrap and reset mid-operation: last_q=3 with port 0 valid. Expect grant 0. Assert rst_i while arb_valid_o=1. Expect arb_valid_o=0 immediately, without waiting for a clock edge.
- Statistics (NX_ARB_STATS_EN): preload port 0's counter to 16'hFFFE. Two more port-0 grants leave it at 16'hFFFF. Then assert stats_clear_i together with a grant on port 0. Expect all counters = 0.

Source files
------------

// File: rtl/nx_stream_arbiter_rr.sv
// nx_stream_arbiter_rr: merges PORTS valid/ready streams into one registered, source-tagged output.
// Optional per-port saturating grant counters are built when NX_ARB_STATS_EN is defined.
module nx_stream_arbiter_rr #(
    parameter int STREAM_WIDTH = 32,
    parameter int PORTS        = 4,
    parameter int RR_MODE      = 1,
    localparam int DIR_WIDTH   = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PORTS*STREAM_WIDTH-1:0] in_data_i,
    input  logic [PORTS-1:0]              in_valid_i,
    output logic [PORTS-1:0]              in_ready_o,
    output logic [STREAM_WIDTH-1:0]       arb_data_o,
    output logic [DIR_WIDTH-1:0]          arb_dir_o,
    output logic                          arb_valid_o,
    input  logic                          arb_ready_i,
    output logic                          idle_o
`ifdef NX_ARB_STATS_EN
    ,
    output logic [PORTS*16-1:0]           grant_count_o,
    input  logic                          stats_clear_i
`endif
);

    logic [DIR_WIDTH-1:0]    last_q;
    logic [STREAM_WIDTH-1:0] data_q;
    logic [DIR_WIDTH-1:0]    dir_q;
    logic                    valid_q;

    logic                    can_load;
    logic                    grant_found;
    logic                    grant;
    logic [DIR_WIDTH-1:0]    grant_idx;
    logic [STREAM_WIDTH-1:0] grant_data;

    assign can_load = !valid_q || arb_ready_i;

    // Round-robin scans from the port after the last winner; fixed priority scans from 0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < PORTS; k++) begin
            automatic int idx = (RR_MODE != 0) ? ((int'(last_q) + 1 + k) % PORTS) : k;
            if (!grant_found && in_valid_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = DIR_WIDTH'(idx);
            end
        end
    end

    assign grant      = can_load && grant_found;
    assign grant_data = in_data_i[int'(grant_idx)*STREAM_WIDTH +: STREAM_WIDTH];

    always_comb begin
        in_ready_o = '0;
        if (grant) begin
            in_ready_o[grant_idx] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_q  <= '0;
            dir_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= DIR_WIDTH'(PORTS - 1);
        end else begin
            if (grant) begin
                data_q  <= grant_data;
                dir_q   <= grant_idx;
                valid_q <= 1'b1;
                if (RR_MODE != 0) begin
                    last_q <= grant_idx;
                end
            end else if (arb_ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign arb_data_o  = data_q;
    assign arb_dir_o   = dir_q;
    assign arb_valid_o = valid_q;
    assign idle_o      = !valid_q && (in_valid_i == '0);

`ifdef NX_ARB_STATS_EN
    logic [15:0] count_q [PORTS];

    // NOTE: the counter array is architectural state, so every element is reset, unlike a RAM.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int p = 0; p < PORTS; p++) begin
                count_q[p] <= '0;
            end
        end else if (stats_clear_i) begin
            for (int p = 0; p < PORTS; p++) begin
                count_q[p] <= '0;
            end
        end else if (grant && (count_q[grant_idx] != 16'hFFFF)) begin
            count_q[grant_idx] <= count_q[grant_idx] + 16'd1;
        end
    end

    always_comb begin
        grant_count_o = '0;
        for (int p = 0; p < PORTS; p++) begin
            grant_count_o[p*16 +: 16] = count_q[p];
        end
    end
`endif

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(in_ready_o));

    a_output_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
        (arb_valid_o && !arb_ready_i) |=> (arb_valid_o && $stable(arb_data_o) && $stable(arb_dir_o)));

endmodule

// File: tb/tb_nx_stream_arbiter_rr.sv
// Scoreboard bench for nx_stream_arbiter_rr: randomized per-port senders, a spec-level model that
// predicts grants, and a monitor that pops expected messages whenever the output transfers.
module tb_nx_stream_arbiter_rr;
    localparam int W  = 32;
    localparam int P  = 4;
    localparam int DW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i;
    logic [P*W-1:0] in_data;
    logic [P-1:0]   in_valid;
    logic [P-1:0]   in_ready;
    logic [W-1:0]   arb_data;
    logic [DW-1:0]  arb_dir;
    logic           arb_valid;
    logic           arb_ready;
    logic           idle;

    logic [P*W-1:0] fp_in_data;
    logic [P-1:0]   fp_in_valid;
    logic [P-1:0]   fp_in_ready;
    logic [W-1:0]   fp_data;
    logic [DW-1:0]  fp_dir;
    logic           fp_valid;
    logic           fp_arb_ready;
    logic           fp_idle;

`ifdef NX_ARB_STATS_EN
    logic           stats_clear;
    logic [P*16-1:0] grant_count;
    logic           fp_clear;
    logic [P*16-1:0] fp_count;
`endif

    nx_stream_arbiter_rr #(.STREAM_WIDTH(W), .PORTS(P), .RR_MODE(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_data_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .arb_data_o(arb_data), .arb_dir_o(arb_dir),
        .arb_valid_o(arb_valid), .arb_ready_i(arb_ready), .idle_o(idle)
`ifdef NX_ARB_STATS_EN
        , .grant_count_o(grant_count), .stats_clear_i(stats_clear)
`endif
    );

    nx_stream_arbiter_rr #(.STREAM_WIDTH(W), .PORTS(P), .RR_MODE(0)) dut_fp (
        .clk_i(clk), .rst_i(rst_i), .in_data_i(fp_in_data), .in_valid_i(fp_in_valid),
        .in_ready_o(fp_in_ready), .arb_data_o(fp_data), .arb_dir_o(fp_dir),
        .arb_valid_o(fp_valid), .arb_ready_i(fp_arb_ready), .idle_o(fp_idle)
`ifdef NX_ARB_STATS_EN
        , .grant_count_o(fp_count), .stats_clear_i(fp_clear)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [W-1:0]  data;
        logic [DW-1:0] dir;
    } msg_t;

    msg_t exp_q[$];

    // Reference model: per-port pending messages plus the spec's arbitration rules.
    bit           pend[P];
    logic [W-1:0] pend_data[P];
    int           m_last;
    bit           m_valid;
    int           m_cnt[P];
    bit           clr_req;

    task automatic model_reset();
        exp_q.delete();
        m_valid = 1'b0;
        m_last  = P - 1;
        for (int p = 0; p < P; p++) begin
            pend[p]  = 1'b0;
            m_cnt[p] = 0;
        end
    endtask

    // One cycle: drive senders after the edge, predict and check at the falling edge.
    task automatic step(input int p_new, input int p_rdy, input logic [P-1:0] mask);
        int   g;
        bit   found;
        logic [P*16-1:0] exp_cnt;
        @(posedge clk);
        #1;
        for (int p = 0; p < P; p++) begin
            if (!pend[p] && mask[p] && ($urandom_range(99) < p_new)) begin
                pend[p]      = 1'b1;
                pend_data[p] = $urandom();
            end
            in_valid[p]       = pend[p];
            in_data[p*W +: W] = pend_data[p];
        end
        arb_ready = ($urandom_range(99) < p_rdy);
`ifdef NX_ARB_STATS_EN
        stats_clear = clr_req;
        clr_req     = 1'b0;
`endif
        @(negedge clk);
        found = 1'b0;
        g     = 0;
        if (!m_valid || arb_ready) begin
            for (int k = 1; k <= P; k++) begin
                if (!found && pend[(m_last + k) % P]) begin
                    found = 1'b1;
                    g     = (m_last + k) % P;
                end
            end
        end
        check("in_ready", in_ready, found ? (64'd1 << g) : 64'd0);
        check("arb_valid", arb_valid, m_valid);
        check("idle", idle, !m_valid && (in_valid == '0));
`ifdef NX_ARB_STATS_EN
        for (int p = 0; p < P; p++) exp_cnt[p*16 +: 16] = m_cnt[p][15:0];
        check("grant_count", grant_count, exp_cnt);
        if (stats_clear) begin
            for (int p = 0; p < P; p++) m_cnt[p] = 0;
        end else if (found && m_cnt[g] < 65535) begin
            m_cnt[g]++;
        end
`endif
        if (found) begin
            exp_q.push_back('{data: pend_data[g], dir: DW'(g)});
            pend[g] = 1'b0;
            m_last  = g;
            m_valid = 1'b1;
        end else if (arb_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on each output transfer and checks stability under backpressure.
    initial begin
        logic [W-1:0]  prev_data;
        logic [DW-1:0] prev_dir;
        bit            hold;
        msg_t          m;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_i) begin
                hold = 1'b0;
                continue;
            end
            if (hold) begin
                check("hold_data", arb_data, prev_data);
                check("hold_dir", arb_dir, prev_dir);
            end
            if (arb_valid && arb_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", arb_valid, 0);
                end else begin
                    m = exp_q.pop_front();
                    check("out_data", arb_data, m.data);
                    check("out_dir", arb_dir, m.dir);
                end
            end
            hold      = arb_valid && !arb_ready;
            prev_data = arb_data;
            prev_dir  = arb_dir;
        end
    end

    initial begin
        rst_i        = 1'b0;
        in_valid     = '0;
        in_data      = '0;
        arb_ready    = 1'b0;
        fp_in_valid  = '0;
        fp_in_data   = '0;
        fp_arb_ready = 1'b1;
        clr_req      = 1'b0;
`ifdef NX_ARB_STATS_EN
        stats_clear  = 1'b0;
        fp_clear     = 1'b0;
`endif
        for (int p = 0; p < P; p++) pend_data[p] = '0;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", arb_valid, 0);
        check("rst_data", arb_data, 0);
        check("rst_dir", arb_dir, 0);
        check("rst_ready", in_ready, 0);
        check("rst_idle", idle, 1);
        rst_i = 1'b1;

        // Single sender on port 2.
        pend[2]      = 1'b1;
        pend_data[2] = 32'hA5;
        step(0, 100, '0);
        step(0, 100, '0);

        // All ports saturated with a ready sink: strict rotation, no bubbles.
        repeat (16) step(100, 100, 4'hF);
        repeat (3) step(0, 100, '0);

        // Backpressure: hold port 1's message while port 3 waits, then handoff with no bubble.
        pend[1]      = 1'b1;
        pend_data[1] = 32'h0000_1111;
        step(0, 100, '0);
        repeat (3) step(100, 0, 4'b1000);
        step(0, 100, '0);
        step(0, 100, '0);

        // Random traffic with random backpressure.
        repeat (3000) step(40, 60, 4'hF);
        repeat (4) step(0, 100, '0);

        // Wrap from port 3 to port 0, then reset while a message is held.
        pend[3]      = 1'b1;
        pend_data[3] = 32'h3333_0003;
        step(0, 100, '0);
        pend[0]      = 1'b1;
        pend_data[0] = 32'h0000_0A0A;
        step(0, 100, '0);
        step(0, 0, '0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("async_reset_valid", arb_valid, 0);
        check("async_reset_data", arb_data, 0);
        in_valid  = '0;
        arb_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b1;
        repeat (300) step(50, 70, 4'hF);
        repeat (4) step(0, 100, '0);

        // Fixed priority: port 1 keeps winning over port 3 until it drops valid.
        @(posedge clk);
        #1;
        fp_in_valid            = 4'b1010;
        fp_in_data[1*W +: W]   = 32'h11;
        fp_in_data[3*W +: W]   = 32'h33;
        @(negedge clk);
        check("fp_ready_first", fp_in_ready, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            fp_in_data[1*W +: W] = 32'h12 + i;
            @(negedge clk);
            check("fp_ready_hold", fp_in_ready, 4'b0010);
            check("fp_dir_p1", fp_dir, 1);
            check("fp_data_p1", fp_data, 32'h11 + i);
        end
        @(posedge clk);
        #1;
        fp_in_valid = 4'b1000;
        @(negedge clk);
        check("fp_ready_p3", fp_in_ready, 4'b1000);
        check("fp_data_last_p1", fp_data, 32'h14);
        @(posedge clk);
        #1;
        fp_in_valid = '0;
        @(negedge clk);
        check("fp_valid_p3", fp_valid, 1);
        check("fp_dir_p3", fp_dir, 3);
        check("fp_data_p3", fp_data, 32'h33);

`ifdef NX_ARB_STATS_EN
        // Drive port 0's counter up to saturation, then clear it while port 0 is granted.
        while (m_cnt[0] != 16'hFFFE) step(100, 100, 4'b0001);
        repeat (2) step(100, 100, 4'b0001);
        check("count_saturated", grant_count[15:0], 16'hFFFF);
        clr_req = 1'b1;
        step(100, 100, 4'b0001);
        step(0, 100, '0);
        check("count_cleared", grant_count, '0);
`endif

        repeat (4) step(0, 100, '0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
